lcd_sequencer_mips: RTL and testbench
=====================================

Name: lcd_sequencer_mips

Overview:
- Command/character sequencer that sits directly upstream of the LCD byte-write controller and drives its DATA / RS / start inputs.
- After reset it runs the HD44780 power-up init sequence.
- It then drains a small FIFO of CPU writes (from the MIPS I/O-mapped port) one byte per controller handshake.
- It tracks the cursor column and automatically inserts line-2 and wrap-around address commands for a 16x2 display.

Parameters:
- PWRUP_CYCLES, 16'd50000: idle cycles after reset before the first init command.
- CLR_WAIT, 16'd4000: extra idle cycles after any clear (0x01) or home (0x02) command completes.
- FIFO_DEPTH, 16: CPU write FIFO entries; must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  CPU write strobe; one entry accepted per cycle when not full.
- wr_rs  in  1  0 = command byte, 1 = character byte.
- wr_data  in  8  byte to queue.
- full  out  1  FIFO full; writes are dropped while high.
- overflow  out  1  sticky; set by any wr_en while full, cleared only by reset.
- init_done  out  1  high once the 5-command init sequence has completed.
- busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE.
- lcd_data  out  8  byte to the controller.
- lcd_rs  out  1  RS to the controller.
- lcd_start  out  1  request to the controller.
- lcd_done  in  1  controller done flag; high = idle/finished.

Behaviour:
- Reset values: lcd_data=0, lcd_rs=0, lcd_start=0, full=0, overflow=0, init_done=0, busy=1. FIFO is flushed, column counter col=0, FSM=PWRUP, delay counter=0.
- Reset asserted mid-operation aborts any transfer and restarts from PWRUP next cycle.
- FIFO: entries are 9 bits {rs, data}, first-in first-out.
  - Write and pop in the same cycle while full: the write is accepted.
  - Writes are accepted during PWRUP/INIT and are held until init_done.
- Handshake with the controller (every byte):
  - Drive lcd_data/lcd_rs, then assert lcd_start.
  - Hold lcd_start high until lcd_done is sampled 0, then drop lcd_start.
  - Wait until lcd_done is sampled 1: the transfer is complete.
  - lcd_data/lcd_rs stay stable from the lcd_start assertion until completion.
  - lcd_start is never asserted unless lcd_done=1.
- FSM states:
  - PWRUP: count PWRUP_CYCLES, then go to INIT.
  - INIT: issue ROM bytes 0x38, 0x0C, 0x01, 0x06, 0x80 in order, rs=0, each via ISSUE/WAIT_LO/WAIT_HI. The CLR_WAIT delay applies after 0x01. After 0x80, set init_done=1 and col=0, then go to IDLE.
  - IDLE: if FIFO is non-empty, go to FETCH.
  - FETCH: examine the head entry without popping it.
    - If rs=1 and col==16: issue inserted command 0xC0 and set col=16 (head not popped).
    - If rs=1 and col==32: issue 0x80 and set col=0 (head not popped).
    - Otherwise pop the head and issue it.
  - ISSUE: assert lcd_start, go to WAIT_LO.
  - WAIT_LO: on lcd_done==0, drop lcd_start and go to WAIT_HI.
  - WAIT_HI: on lcd_done==1, apply the column update, then go to POSTWAIT if the byte was 0x01 or 0x02 with rs=0, else return to INIT or IDLE.
  - POSTWAIT: count CLR_WAIT, then return to INIT or IDLE.
- Column update (6-bit col, range 0..32):
  - rs=1: col+1.
  - rs=0 with 0x01 or 0x02: col=0.
  - rs=0 with data[7]=1: col={data[6],data[3:0]}, i.e. addresses 0x00-0x0F map to 0-15 and 0x40-0x4F map to 16-31.
  - Any other command: col unchanged.
- Inserted commands are not counted as FIFO pops and do not raise busy beyond its normal definition.

Test Plan:
- Reset, controller model with 20-cycle done latency, PWRUP_CYCLES=10 -> bytes 0x38,0x0C,0x01,0x06,0x80 appear with rs=0 in order. A gap of >= CLR_WAIT cycles follows 0x01 completion. init_done rises after 0x80 completes.
- After init, write 'H','i' (rs=1) -> controller receives 0x48, 0x49, rs=1. busy falls after the second lcd_done rise. lcd_start never rises while lcd_done=0.
- Write 17 characters 0x41..0x51 -> 16 chars, then command 0xC0 (rs=0), then 0x51. Write 16 more -> after the 32nd char, 0x80 is inserted before the 33rd.
- FIFO_DEPTH=16: write 17 entries back-to-back during PWRUP -> full=1 after the 16th, the 17th is dropped, overflow=1 sticky. The 16 queued entries drain after init in order.
- Write command 0xC5 then char 'X' -> col becomes 21; 'X' is issued with no inserted command. Write 0x01 -> col=0 and the CLR_WAIT gap is observed.
- Assert reset while in WAIT_LO -> next cycle lcd_start=0, FIFO empty, init_done=0, and the init sequence restarts.

Source files
------------

// File: rtl/lcd_sequencer_mips.sv
// HD44780 command/character sequencer: power-up init, CPU write FIFO drain and
// automatic cursor line management for a 16x2 display, feeding the LCD byte writer.
`timescale 1ns/1ps
module lcd_sequencer_mips #(
    parameter logic [15:0] PWRUP_CYCLES = 16'd50000,
    parameter logic [15:0] CLR_WAIT     = 16'd4000,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       wr_en_i,
    input  logic       wr_rs_i,
    input  logic [7:0] wr_data_i,
    output logic       full_o,
    output logic       overflow_o,
    output logic       init_done_o,
    output logic       busy_o,
    output logic [7:0] lcd_data_o,
    output logic       lcd_rs_o,
    output logic       lcd_start_o,
    input  logic       lcd_done_i,
    output logic [3:0] dbg_state_o,
    output logic [5:0] dbg_col_o
);
    localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        S_PWRUP    = 4'd0,
        S_INIT     = 4'd1,
        S_IDLE     = 4'd2,
        S_FETCH    = 4'd3,
        S_ISSUE    = 4'd4,
        S_WAIT_LO  = 4'd5,
        S_WAIT_HI  = 4'd6,
        S_POSTWAIT = 4'd7
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dly_q, dly_d;
    logic [2:0]  rom_idx_q, rom_idx_d;
    logic [5:0]  col_q, col_d;
    logic        addr_set_q, addr_set_d;
    logic        init_done_q, init_done_d;
    logic [7:0]  lcd_data_q, lcd_data_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic        lcd_start_q, lcd_start_d;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          fifo_empty, push, pop;
    logic [8:0]    head;
    logic [16:0]   dly_inc;
    logic          is_clr_home;
    state_t        ret_state;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    init_rom = 8'h38;
            3'd1:    init_rom = 8'h0C;
            3'd2:    init_rom = 8'h01;
            3'd3:    init_rom = 8'h06;
            default: init_rom = 8'h80;
        endcase
    endfunction

    assign fifo_empty  = (count_q == '0);
    assign full_o      = (count_q == DEPTH_C);
    assign push        = wr_en_i && (!full_o || pop);
    assign head        = mem_q[rd_ptr_q];
    assign dly_inc     = {1'b0, dly_q} + 17'd1;
    assign is_clr_home = !lcd_rs_q && ((lcd_data_q == 8'h01) || (lcd_data_q == 8'h02));
    assign ret_state   = init_done_q ? S_IDLE : S_INIT;

    // Byte handshake: data/rs are loaded before lcd_start rises and are held until the
    // controller returns lcd_done high; lcd_start rises only while lcd_done is high and
    // falls once lcd_done has been seen low.
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        rom_idx_d   = rom_idx_q;
        col_d       = col_q;
        addr_set_d  = addr_set_q;
        init_done_d = init_done_q;
        lcd_data_d  = lcd_data_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_start_d = lcd_start_q;
        pop         = 1'b0;
        case (state_q)
            S_PWRUP: begin
                if (dly_inc >= {1'b0, PWRUP_CYCLES}) begin
                    dly_d   = '0;
                    state_d = S_INIT;
                end else begin
                    dly_d = dly_inc[15:0];
                end
            end
            S_INIT: begin
                if (rom_idx_q == 3'd5) begin
                    init_done_d = 1'b1;
                    col_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    lcd_data_d = init_rom(rom_idx_q);
                    lcd_rs_d   = 1'b0;
                    rom_idx_d  = rom_idx_q + 3'd1;
                    state_d    = S_ISSUE;
                end
            end
            S_IDLE: begin
                if (!fifo_empty) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_ISSUE;
                // addr_set_q stops col==16 re-inserting 0xC0 after the line-2 address is set
                if (head[8] && (col_q == 6'd16) && !addr_set_q) begin
                    lcd_data_d = 8'hC0;
                    lcd_rs_d   = 1'b0;
                end else if (head[8] && (col_q == 6'd32)) begin
                    lcd_data_d = 8'h80;
                    lcd_rs_d   = 1'b0;
                end else begin
                    pop        = 1'b1;
                    lcd_data_d = head[7:0];
                    lcd_rs_d   = head[8];
                end
            end
            S_ISSUE: begin
                if (lcd_done_i) begin
                    lcd_start_d = 1'b1;
                    state_d     = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!lcd_done_i) begin
                    lcd_start_d = 1'b0;
                    state_d     = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (lcd_done_i) begin
                    if (lcd_rs_q) begin
                        col_d      = col_q + 6'd1;
                        addr_set_d = 1'b0;
                    end else if (is_clr_home) begin
                        col_d      = '0;
                        addr_set_d = 1'b0;
                    end else if (lcd_data_q[7]) begin
                        col_d      = {1'b0, lcd_data_q[6], lcd_data_q[3:0]};
                        addr_set_d = 1'b1;
                    end
                    dly_d   = '0;
                    state_d = is_clr_home ? S_POSTWAIT : ret_state;
                end
            end
            S_POSTWAIT: begin
                if (dly_inc >= {1'b0, CLR_WAIT}) begin
                    dly_d   = '0;
                    state_d = ret_state;
                end else begin
                    dly_d = dly_inc[15:0];
                end
            end
            default: state_d = S_PWRUP;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_PWRUP;
            dly_q       <= '0;
            rom_idx_q   <= '0;
            col_q       <= '0;
            addr_set_q  <= 1'b0;
            init_done_q <= 1'b0;
            lcd_data_q  <= '0;
            lcd_rs_q    <= 1'b0;
            lcd_start_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            rom_idx_q   <= rom_idx_d;
            col_q       <= col_d;
            addr_set_q  <= addr_set_d;
            init_done_q <= init_done_d;
            lcd_data_q  <= lcd_data_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_start_q <= lcd_start_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (wr_en_i && full_o) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {wr_rs_i, wr_data_i};
    end

    assign overflow_o  = overflow_q;
    assign init_done_o = init_done_q;
    assign busy_o      = !fifo_empty || (state_q != S_IDLE);
    assign lcd_data_o  = lcd_data_q;
    assign lcd_rs_o    = lcd_rs_q;
    assign lcd_start_o = lcd_start_q;
    assign dbg_state_o = state_q;
    assign dbg_col_o   = col_q;

endmodule

// File: tb/tb_lcd_sequencer_mips.sv
// Directed bench for lcd_sequencer_mips with a 20-cycle LCD controller model that
// logs every byte it accepts.
`timescale 1ns/1ps
module tb_lcd_sequencer_mips;
    localparam logic [15:0] PWR  = 16'd10;
    localparam logic [15:0] CLRW = 16'd40;
    localparam int          LAT  = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, overflow, init_done, busy, lcd_rs, lcd_start;
    logic [7:0] lcd_data;
    logic       lcd_done = 1'b1;
    logic [3:0] dbg_state;
    logic [5:0] dbg_col;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 0;
    int start_viol = 0;
    int stab_viol = 0;
    logic       start_prev = 1'b0;
    logic       aborted = 1'b0;
    logic [8:0] cur = 9'h000;

    logic [8:0] got_q[$];
    int         got_cyc[$];
    int         done_cyc[$];
    logic [8:0] exp_q[$];

    lcd_sequencer_mips #(.PWRUP_CYCLES(PWR), .CLR_WAIT(CLRW), .FIFO_DEPTH(16)) dut (
        .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_rs_i(wr_rs), .wr_data_i(wr_data),
        .full_o(full), .overflow_o(overflow), .init_done_o(init_done), .busy_o(busy),
        .lcd_data_o(lcd_data), .lcd_rs_o(lcd_rs), .lcd_start_o(lcd_start), .lcd_done_i(lcd_done),
        .dbg_state_o(dbg_state), .dbg_col_o(dbg_col)
    );

    always #5 clk = ~clk;

    // Controller model: accepts a byte when start is seen with done high, keeps done low LAT cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lcd_start && !start_prev && !lcd_done) start_viol <= start_viol + 1;
        start_prev <= lcd_start;
        if (lcd_done) begin
            if (lcd_start) begin
                lcd_done <= 1'b0;
                lat      <= LAT;
                cur      <= {lcd_rs, lcd_data};
                aborted  <= 1'b0;
                got_q.push_back({lcd_rs, lcd_data});
                got_cyc.push_back(cyc);
            end
        end else begin
            if (reset) aborted <= 1'b1;
            else if (!aborted && ({lcd_rs, lcd_data} !== cur)) stab_viol <= stab_viol + 1;
            if (lat == 1) begin
                lcd_done <= 1'b1;
                done_cyc.push_back(cyc);
            end
            lat <= lat - 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
        done_cyc.delete();
        exp_q.delete();
    endtask

    task automatic cpu_write(input logic rs, input logic [7:0] d);
        int k = 0;
        while (full && k < 2000) begin
            @(negedge clk);
            k++;
        end
        wr_en = 1'b1;
        wr_rs = rs;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok, output int fall);
        int k = 0;
        while ((busy !== 1'b0 || lcd_done !== 1'b1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (busy === 1'b0 && lcd_done === 1'b1);
        fall = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (lcd_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b exp 0", lcd_start); end
        checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h exp 00", lcd_data); end
        checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL rst_rs: got %b exp 0", lcd_rs); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b exp 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b exp 0", overflow); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b exp 0", init_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b exp 1", busy); end
        checks++; if (dbg_state !== 4'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
        clear_log();
        reset = 1'b0;
    endtask

    task automatic test_init();
        bit ok;
        int k = 0;
        int rise;
        logic [8:0] obs;
        exp_q = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
        wait_bytes(5, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL init_timeout: got %0d bytes exp 5", got_q.size()); end
        for (int i = 0; i < 5; i++) begin
            obs = 'x;
            if (i < got_q.size()) obs = got_q[i];
            checks++; if (obs !== exp_q[i]) begin errors++; $display("FAIL init_byte%0d: got %h exp %h", i, obs, exp_q[i]); end
        end
        while (init_done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        rise = cyc;
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %b exp 1", init_done); end
        checks++;
        if (done_cyc.size() < 5 || rise <= done_cyc[4]) begin
            errors++; $display("FAIL init_done_order: rise %0d not after 0x80 completion (%0d entries)", rise, done_cyc.size());
        end
        checks++;
        if (got_cyc.size() < 4 || done_cyc.size() < 3 || (got_cyc[3] - done_cyc[2]) < int'(CLRW)) begin
            errors++; $display("FAIL init_clr_gap: gap too short, need >= %0d", CLRW);
        end
        checks++; if (dbg_col !== 6'd0) begin errors++; $display("FAIL init_col: got %0d exp 0", dbg_col); end
    endtask

    task automatic test_chars();
        bit ok;
        int fall;
        logic [8:0] obs;
        clear_log();
        exp_q = '{9'h148, 9'h149};
        cpu_write(1'b1, 8'h48);
        cpu_write(1'b1, 8'h49);
        wait_bytes(2, 500, ok);
        wait_idle(500, ok, fall);
        checks++; if (!ok) begin errors++; $display("FAIL chars_idle: busy=%b still high", busy); end
        for (int i = 0; i < 2; i++) begin
            obs = 'x;
            if (i < got_q.size()) obs = got_q[i];
            checks++; if (obs !== exp_q[i]) begin errors++; $display("FAIL chars_byte%0d: got %h exp %h", i, obs, exp_q[i]); end
        end
        checks++;
        if (done_cyc.size() < 2 || fall <= done_cyc[1]) begin
            errors++; $display("FAIL chars_busy_fall: busy fell at %0d, before second completion", fall);
        end
        checks++; if (dbg_col !== 6'd2) begin errors++; $display("FAIL chars_col: got %0d exp 2", dbg_col); end
    endtask

    task automatic test_wrap();
        bit ok;
        int fall;
        logic [8:0] obs;
        clear_log();
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(8'h41 + i)});
        exp_q.push_back(9'h0C0);
        exp_q.push_back(9'h151);
        for (int i = 0; i < 15; i++) exp_q.push_back({1'b1, 8'(8'h52 + i)});
        exp_q.push_back(9'h080);
        exp_q.push_back(9'h161);
        cpu_write(1'b0, 8'h80);
        for (int i = 0; i < 33; i++) cpu_write(1'b1, 8'(8'h41 + i));
        wait_bytes(36, 3000, ok);
        wait_idle(3000, ok, fall);
        checks++; if (got_q.size() != 36) begin errors++; $display("FAIL wrap_count: got %0d bytes exp 36", got_q.size()); end
        for (int i = 0; i < 36; i++) begin
            obs = 'x;
            if (i < got_q.size()) obs = got_q[i];
            checks++; if (obs !== exp_q[i]) begin errors++; $display("FAIL wrap_byte%0d: got %h exp %h", i, obs, exp_q[i]); end
        end
        checks++; if (dbg_col !== 6'd1) begin errors++; $display("FAIL wrap_col: got %0d exp 1", dbg_col); end
    endtask

    task automatic test_addr();
        bit ok;
        int fall;
        logic [8:0] obs;
        clear_log();
        cpu_write(1'b0, 8'hC5);
        wait_idle(500, ok, fall);
        obs = 'x;
        if (got_q.size() > 0) obs = got_q[0];
        checks++; if (obs !== 9'h0C5) begin errors++; $display("FAIL addr_cmd: got %h exp 0c5", obs); end
        checks++; if (dbg_col !== 6'd21) begin errors++; $display("FAIL addr_col21: got %0d exp 21", dbg_col); end
        clear_log();
        cpu_write(1'b1, 8'h58);
        wait_idle(500, ok, fall);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL addr_no_insert: got %0d bytes exp 1", got_q.size()); end
        obs = 'x;
        if (got_q.size() > 0) obs = got_q[0];
        checks++; if (obs !== 9'h158) begin errors++; $display("FAIL addr_char: got %h exp 158", obs); end
        checks++; if (dbg_col !== 6'd22) begin errors++; $display("FAIL addr_col22: got %0d exp 22", dbg_col); end
        clear_log();
        cpu_write(1'b0, 8'h01);
        wait_idle(1000, ok, fall);
        obs = 'x;
        if (got_q.size() > 0) obs = got_q[0];
        checks++; if (obs !== 9'h001) begin errors++; $display("FAIL clr_cmd: got %h exp 001", obs); end
        checks++; if (dbg_col !== 6'd0) begin errors++; $display("FAIL clr_col: got %0d exp 0", dbg_col); end
        checks++;
        if (done_cyc.size() < 1 || (fall - done_cyc[0]) < int'(CLRW)) begin
            errors++; $display("FAIL clr_gap: busy fell at %0d, need >= %0d cycles after completion", fall, CLRW);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int fall;
        logic [8:0] obs;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_log();
        exp_q = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(8'h30 + i)});
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_rs = 1'b1;
            wr_data = 8'(8'h30 + i);
            @(negedge clk);
            if (i == 14) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_full15: got %b exp 0", full); end
            end
            if (i == 15) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full16: got %b exp 1", full); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b exp 0", overflow); end
            end
        end
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", overflow); end
        wait_bytes(21, 2000, ok);
        wait_idle(2000, ok, fall);
        checks++; if (got_q.size() != 21) begin errors++; $display("FAIL ovf_count: got %0d bytes exp 21", got_q.size()); end
        for (int i = 0; i < 21; i++) begin
            obs = 'x;
            if (i < got_q.size()) obs = got_q[i];
            checks++; if (obs !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d: got %h exp %h", i, obs, exp_q[i]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b exp 1", overflow); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_full_end: got %b exp 0", full); end
        checks++; if (dbg_col !== 6'd16) begin errors++; $display("FAIL ovf_col: got %0d exp 16", dbg_col); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int fall;
        int k = 0;
        logic [8:0] obs;
        cpu_write(1'b1, 8'h5A);
        cpu_write(1'b1, 8'h59);
        while (dbg_state !== 4'd5 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++; if (dbg_state !== 4'd5 || lcd_start !== 1'b1) begin errors++; $display("FAIL mid_reach_wait_lo: state %0d start %b", dbg_state, lcd_start); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (lcd_start !== 1'b0) begin errors++; $display("FAIL mid_start: got %b exp 0", lcd_start); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_init_done: got %b exp 0", init_done); end
        checks++; if (dbg_state !== 4'd0) begin errors++; $display("FAIL mid_state: got %0d exp 0", dbg_state); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b exp 0", overflow); end
        clear_log();
        @(negedge clk);
        reset = 1'b0;
        exp_q = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
        wait_bytes(5, 1000, ok);
        wait_idle(1000, ok, fall);
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL mid_flush: got %0d bytes exp 5", got_q.size()); end
        for (int i = 0; i < 5; i++) begin
            obs = 'x;
            if (i < got_q.size()) obs = got_q[i];
            checks++; if (obs !== exp_q[i]) begin errors++; $display("FAIL mid_byte%0d: got %h exp %h", i, obs, exp_q[i]); end
        end
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL mid_reinit: got %b exp 1", init_done); end
    endtask

    task automatic test_protocol();
        checks++; if (start_viol != 0) begin errors++; $display("FAIL proto_start: %0d rises with done low, exp 0", start_viol); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL proto_stable: %0d data changes mid-transfer, exp 0", stab_viol); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_chars();
        test_wrap();
        test_addr();
        test_overflow();
        test_reset_mid();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
